// File: rtl/rc4_pkg.sv
// Shared RC4 types, state encodings and character constants for the encrypt and decode FSMs.
package rc4_pkg;

    localparam int S_SIZE = 256;

    typedef logic [7:0] rc4_byte_t;

    localparam rc4_byte_t CHAR_SPACE = 8'h20;
    localparam rc4_byte_t CHAR_A_LO  = 8'h61;
    localparam rc4_byte_t CHAR_Z_LO  = 8'h7A;

    typedef logic [4:0] rc4_state_t;

    // One PRGA byte walks ST_INC_I..ST_INC_K, sixteen states in order
    localparam rc4_state_t ST_IDLE   = 5'd0;
    localparam rc4_state_t ST_INC_I  = 5'd1;
    localparam rc4_state_t ST_RD_SI  = 5'd2;
    localparam rc4_state_t ST_CAP_SI = 5'd3;
    localparam rc4_state_t ST_ADD_J  = 5'd4;
    localparam rc4_state_t ST_RD_SJ  = 5'd5;
    localparam rc4_state_t ST_CAP_SJ = 5'd6;
    localparam rc4_state_t ST_WR_J   = 5'd7;
    localparam rc4_state_t ST_WR_I   = 5'd8;
    localparam rc4_state_t ST_ADD_F  = 5'd9;
    localparam rc4_state_t ST_RD_F   = 5'd10;
    localparam rc4_state_t ST_CAP_F  = 5'd11;
    localparam rc4_state_t ST_RD_PT  = 5'd12;
    localparam rc4_state_t ST_CAP_PT = 5'd13;
    localparam rc4_state_t ST_XOR    = 5'd14;
    localparam rc4_state_t ST_WR_CT  = 5'd15;
    localparam rc4_state_t ST_INC_K  = 5'd16;
    localparam rc4_state_t ST_DONE   = 5'd17;
    localparam rc4_state_t ST_ERROR  = 5'd18;

    function automatic logic is_text_char(input rc4_byte_t b);
        return ((b >= CHAR_A_LO) && (b <= CHAR_Z_LO)) || (b == CHAR_SPACE);
    endfunction

endpackage

// File: rtl/rc4_prga_core.sv
// RC4 PRGA datapath: i/j/idx registers, captured S[i]/S[j], and the S RAM address/data mux.
module rc4_prga_core
    import rc4_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic [4:0] state,
    input  logic       clear,
    input  logic [7:0] s_data_in,
    output logic [7:0] s_address,
    output logic [7:0] s_data_out,
    output logic       s_write_en
);

    rc4_byte_t i_reg, j_reg, idx_reg, si_reg, sj_reg;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            i_reg   <= '0;
            j_reg   <= '0;
            idx_reg <= '0;
            si_reg  <= '0;
            sj_reg  <= '0;
        end else if (clear) begin
            i_reg <= '0;
            j_reg <= '0;
        end else begin
            case (state)
                ST_INC_I:  i_reg   <= i_reg + 8'd1;
                ST_CAP_SI: si_reg  <= s_data_in;
                ST_ADD_J:  j_reg   <= j_reg + si_reg;
                ST_CAP_SJ: sj_reg  <= s_data_in;
                ST_ADD_F:  idx_reg <= si_reg + sj_reg;
                default: ;
            endcase
        end
    end

    // Address is held through both the read and capture cycles of each access
    always_comb begin
        s_address  = '0;
        s_data_out = '0;
        s_write_en = 1'b0;
        case (state)
            ST_RD_SI, ST_CAP_SI: s_address = i_reg;
            ST_RD_SJ, ST_CAP_SJ: s_address = j_reg;
            ST_RD_F,  ST_CAP_F:  s_address = idx_reg;
            ST_WR_J: begin
                s_address  = j_reg;
                s_data_out = si_reg;
                s_write_en = 1'b1;
            end
            ST_WR_I: begin
                s_address  = i_reg;
                s_data_out = sj_reg;
                s_write_en = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/rc4_encrypt_fsm.sv
// RC4 PRGA encryptor: plaintext memory in, ciphertext RAM out, 16 cycles per byte.
// Define RC4_PT_CHECK_EN to reject bytes outside lowercase a-z and space.
module rc4_encrypt_fsm
    import rc4_pkg::*;
#(
    parameter int MSG_LEN = 32,
    parameter int K_W     = $clog2(MSG_LEN) + 1
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    output logic [7:0] s_address,
    input  logic [7:0] s_data_in,
    output logic [7:0] s_data_out,
    output logic       s_write_en,
    output logic [7:0] pt_address,
    input  logic [7:0] pt_data,
    output logic [7:0] ct_address,
    output logic [7:0] ct_data,
    output logic       ct_write_en,
    output logic       done,
    output logic       bad_char
);

    rc4_state_t     state_reg, state_next;
    logic [K_W-1:0] k_reg;
    rc4_byte_t      f_reg, p_reg, ct_reg;
    logic           start_accept;
    logic           last_byte;

    assign start_accept = (state_reg == ST_IDLE) && start;
    assign last_byte    = (k_reg == K_W'(MSG_LEN - 1));

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (start) state_next = ST_INC_I;
            ST_INC_I:  state_next = ST_RD_SI;
            ST_RD_SI:  state_next = ST_CAP_SI;
            ST_CAP_SI: state_next = ST_ADD_J;
            ST_ADD_J:  state_next = ST_RD_SJ;
            ST_RD_SJ:  state_next = ST_CAP_SJ;
            ST_CAP_SJ: state_next = ST_WR_J;
            ST_WR_J:   state_next = ST_WR_I;
            ST_WR_I:   state_next = ST_ADD_F;
            ST_ADD_F:  state_next = ST_RD_F;
            ST_RD_F:   state_next = ST_CAP_F;
            ST_CAP_F:  state_next = ST_RD_PT;
            ST_RD_PT:  state_next = ST_CAP_PT;
            ST_CAP_PT: state_next = ST_XOR;
`ifdef RC4_PT_CHECK_EN
            ST_XOR:    state_next = is_text_char(p_reg) ? ST_WR_CT : ST_ERROR;
            ST_ERROR:  if (!start) state_next = ST_IDLE;
`else
            ST_XOR:    state_next = ST_WR_CT;
`endif
            ST_WR_CT:  state_next = ST_INC_K;
            ST_INC_K:  state_next = last_byte ? ST_DONE : ST_INC_I;
            ST_DONE:   if (!start) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
            k_reg     <= '0;
            f_reg     <= '0;
            p_reg     <= '0;
            ct_reg    <= '0;
        end else begin
            state_reg <= state_next;
            if (start_accept)
                k_reg <= '0;
            else if (state_reg == ST_INC_K)
                k_reg <= k_reg + 1'b1;
            if (state_reg == ST_CAP_F)  f_reg  <= s_data_in;
            if (state_reg == ST_CAP_PT) p_reg  <= pt_data;
            if (state_reg == ST_XOR)    ct_reg <= f_reg ^ p_reg;
        end
    end

    rc4_prga_core u_core (
        .clock      (clock),
        .reset_n    (reset_n),
        .state      (state_reg),
        .clear      (start_accept),
        .s_data_in  (s_data_in),
        .s_address  (s_address),
        .s_data_out (s_data_out),
        .s_write_en (s_write_en)
    );

    assign pt_address  = 8'(k_reg);
    assign ct_address  = 8'(k_reg);
    assign ct_data     = ct_reg;
    assign ct_write_en = (state_reg == ST_WR_CT);
    assign done        = (state_reg == ST_DONE);
`ifdef RC4_PT_CHECK_EN
    assign bad_char    = (state_reg == ST_ERROR);
`else
    assign bad_char    = 1'b0;
`endif

endmodule

// File: tb/tb_rc4_encrypt_fsm.sv
// Directed bench for rc4_encrypt_fsm: identity-S vectors, RC4("Key","Plaintext"), round trip, reset abort, MSG_LEN=1.
module tb_rc4_encrypt_fsm;

    logic       clock = 1'b0;
    logic       reset_n, start, start_1, s_load;
    logic [7:0] s_address, s_data_in, s_data_out, pt_address, pt_data, ct_address, ct_data;
    logic       s_write_en, ct_write_en, done, bad_char;
    logic [7:0] s_address_1, s_data_in_1, s_data_out_1, pt_address_1, pt_data_1, ct_address_1, ct_data_1;
    logic       s_write_en_1, ct_write_en_1, done_1, bad_char_1;

    logic [7:0] s_mem [256];
    logic [7:0] s_mem_1 [256];
    logic [7:0] s_init [256];
    logic [7:0] pt_mem [256];
    logic [7:0] ct_mem [256];
    logic [7:0] orig [32];
    logic [7:0] known [9];
    logic [7:0] key [3];
    int ct_wr_count = 0, s_wr_count = 0, ct_wr_count_1 = 0;
    logic [7:0] ct_last_addr_1 = 8'hFF, ct_last_data_1 = 8'h00;

    int errors = 0, checks = 0;
    int edges, n, ct_before, s_before;
    logic watch_s = 1'b0, s_checked = 1'b0;

    always #5 clock = ~clock;

    rc4_encrypt_fsm #(.MSG_LEN(32)) dut (
        .clock(clock), .reset_n(reset_n), .start(start),
        .s_address(s_address), .s_data_in(s_data_in), .s_data_out(s_data_out), .s_write_en(s_write_en),
        .pt_address(pt_address), .pt_data(pt_data),
        .ct_address(ct_address), .ct_data(ct_data), .ct_write_en(ct_write_en),
        .done(done), .bad_char(bad_char)
    );

    rc4_encrypt_fsm #(.MSG_LEN(1)) dut_1 (
        .clock(clock), .reset_n(reset_n), .start(start_1),
        .s_address(s_address_1), .s_data_in(s_data_in_1), .s_data_out(s_data_out_1), .s_write_en(s_write_en_1),
        .pt_address(pt_address_1), .pt_data(pt_data_1),
        .ct_address(ct_address_1), .ct_data(ct_data_1), .ct_write_en(ct_write_en_1),
        .done(done_1), .bad_char(bad_char_1)
    );

    // Synchronous RAM models: registered read, write on strobe
    always @(posedge clock) begin
        if (s_load) begin
            for (int x = 0; x < 256; x++) s_mem[x] <= s_init[x];
        end else if (s_write_en) begin
            s_mem[s_address] <= s_data_out;
            s_wr_count <= s_wr_count + 1;
        end
        s_data_in <= s_mem[s_address];
        pt_data   <= pt_mem[pt_address];
        if (ct_write_en) begin
            ct_mem[ct_address] <= ct_data;
            ct_wr_count <= ct_wr_count + 1;
        end
    end

    always @(posedge clock) begin
        if (s_load) begin
            for (int x = 0; x < 256; x++) s_mem_1[x] <= s_init[x];
        end else if (s_write_en_1) begin
            s_mem_1[s_address_1] <= s_data_out_1;
        end
        s_data_in_1 <= s_mem_1[s_address_1];
        pt_data_1   <= pt_mem[pt_address_1];
        if (ct_write_en_1) begin
            ct_last_addr_1 <= ct_address_1;
            ct_last_data_1 <= ct_data_1;
            ct_wr_count_1  <= ct_wr_count_1 + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic load_s();
        @(negedge clock) s_load = 1'b1;
        @(negedge clock) s_load = 1'b0;
    endtask

    task automatic load_identity();
        for (int x = 0; x < 256; x++) s_init[x] = 8'(x);
        load_s();
    endtask

    // Raise start, then count rising edges after the sampling edge until done
    task automatic run_timed(output int cnt);
        @(negedge clock) start = 1'b1;
        @(posedge clock);
        cnt = 0;
        while (!done && cnt < 2000) begin
            @(posedge clock);
            #1;
            cnt++;
            if (watch_s && !s_checked && pt_address == 8'd2) begin
                check_eq("id_s2_after_byte1", 64'(s_mem[2]), 64'h03);
                check_eq("id_s3_after_byte1", 64'(s_mem[3]), 64'h02);
                s_checked = 1'b1;
            end
        end
        $display("run: done after %0d edges, ct writes so far %0d", cnt, ct_wr_count);
    endtask

    task automatic stop_run();
        @(negedge clock) start = 1'b0;
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; start = 1'b0; start_1 = 1'b0; s_load = 1'b0;
        for (int x = 0; x < 256; x++) pt_mem[x] = 8'h20;
        load_identity();
        #1;
        check_eq("reset_outputs",
                 {20'd0, s_address, s_data_out, s_write_en, pt_address, ct_address, ct_data, ct_write_en, done, bad_char},
                 64'd0);
        check_eq("reset_outputs_len1", {62'd0, ct_write_en_1, done_1}, 64'd0);
        @(negedge clock) reset_n = 1'b1;

        // Identity S, plaintext all spaces
        watch_s = 1'b1;
        ct_before = ct_wr_count;
        run_timed(edges);
        watch_s = 1'b0;
        check_eq("id_done_edges", 64'(edges), 64'd512);
        check_eq("id_s_watch_seen", 64'(s_checked), 64'd1);
        check_eq("id_ct0", 64'(ct_mem[0]), 64'h22);
        check_eq("id_ct1", 64'(ct_mem[1]), 64'h25);
        check_eq("id_ct_writes", 64'(ct_wr_count - ct_before), 64'd32);

        // Hold start after done: no further activity
        ct_before = ct_wr_count; s_before = s_wr_count;
        repeat (20) @(negedge clock);
        check_eq("hold_done_high", 64'(done), 64'd1);
        check_eq("hold_no_ct_writes", 64'(ct_wr_count - ct_before), 64'd0);
        check_eq("hold_no_s_writes", 64'(s_wr_count - s_before), 64'd0);
        stop_run();
        check_eq("drop_start_done_low", 64'(done), 64'd0);
        ct_before = ct_wr_count;
        run_timed(edges);
        check_eq("second_run_edges", 64'(edges), 64'd512);
        check_eq("second_run_ct_writes", 64'(ct_wr_count - ct_before), 64'd32);
        stop_run();

`ifndef RC4_PT_CHECK_EN
        // RC4 key "Key", plaintext "Plaintext" -> BB F3 16 E8 D9 40 AF 0A D3
        key[0] = 8'h4B; key[1] = 8'h65; key[2] = 8'h79;
        known[0] = 8'hBB; known[1] = 8'hF3; known[2] = 8'h16; known[3] = 8'hE8; known[4] = 8'hD9;
        known[5] = 8'h40; known[6] = 8'hAF; known[7] = 8'h0A; known[8] = 8'hD3;
        orig[0] = 8'h50; orig[1] = 8'h6C; orig[2] = 8'h61; orig[3] = 8'h69; orig[4] = 8'h6E;
        orig[5] = 8'h74; orig[6] = 8'h65; orig[7] = 8'h78; orig[8] = 8'h74;
        for (int x = 9; x < 32; x++) orig[x] = 8'h61 + 8'(x % 26);
        for (int x = 0; x < 32; x++) pt_mem[x] = orig[x];
        begin
            logic [7:0] j, t;
            for (int x = 0; x < 256; x++) s_init[x] = 8'(x);
            j = 8'd0;
            for (int x = 0; x < 256; x++) begin
                j = j + s_init[x] + key[x % 3];
                t = s_init[x]; s_init[x] = s_init[j]; s_init[j] = t;
            end
        end
        load_s();
        run_timed(edges);
        check_eq("ksa_run_edges", 64'(edges), 64'd512);
        for (int x = 0; x < 9; x++) check_eq($sformatf("known_ct%0d", x), 64'(ct_mem[x]), 64'(known[x]));
        stop_run();
        for (int x = 0; x < 32; x++) pt_mem[x] = ct_mem[x];
        load_s();
        run_timed(edges);
        for (int x = 0; x < 32; x++) check_eq($sformatf("roundtrip%0d", x), 64'(ct_mem[x]), 64'(orig[x]));
        stop_run();
`else
        // Byte 3 is uppercase: ERROR after its XOR cycle, three ciphertext writes
        for (int x = 0; x < 32; x++) pt_mem[x] = 8'h61 + 8'(x % 26);
        pt_mem[3] = 8'h41;
        load_identity();
        ct_before = ct_wr_count;
        @(negedge clock) start = 1'b1;
        @(posedge clock);
        edges = 0;
        while (!bad_char && edges < 2000) begin
            @(posedge clock); #1; edges++;
        end
        $display("run: bad_char after %0d edges", edges);
        check_eq("err_edges", 64'(edges), 64'd62);
        check_eq("err_ct_writes", 64'(ct_wr_count - ct_before), 64'd3);
        repeat (5) @(negedge clock);
        check_eq("err_hold_bad_char", 64'(bad_char), 64'd1);
        check_eq("err_done_low", 64'(done), 64'd0);
        check_eq("err_ct_writes_hold", 64'(ct_wr_count - ct_before), 64'd3);
        stop_run();
        check_eq("err_release_bad_char", 64'(bad_char), 64'd0);
        for (int x = 0; x < 256; x++) pt_mem[x] = 8'h20;
`endif

        // Reset asserted during WR_J of byte 5
        for (int x = 0; x < 256; x++) pt_mem[x] = 8'h20;
        load_identity();
        @(negedge clock) start = 1'b1;
        n = 0;
        while (!(s_write_en && pt_address == 8'd5) && n < 2000) begin
            @(negedge clock); n++;
        end
        check_eq("reach_wr_j_byte5", 64'(n < 2000), 64'd1);
        ct_before = ct_wr_count; s_before = s_wr_count;
        reset_n = 1'b0; start = 1'b0;
        #1;
        check_eq("abort_outputs",
                 {20'd0, s_address, s_data_out, s_write_en, pt_address, ct_address, ct_data, ct_write_en, done, bad_char},
                 64'd0);
        repeat (5) @(posedge clock);
        #1;
        check_eq("abort_no_s_writes", 64'(s_wr_count - s_before), 64'd0);
        check_eq("abort_no_ct_writes", 64'(ct_wr_count - ct_before), 64'd0);
        @(negedge clock) reset_n = 1'b1;
        load_identity();
        ct_before = ct_wr_count;
        run_timed(edges);
        check_eq("rerun_edges", 64'(edges), 64'd512);
        check_eq("rerun_ct0", 64'(ct_mem[0]), 64'h22);
        check_eq("rerun_ct1", 64'(ct_mem[1]), 64'h25);
        check_eq("rerun_ct_writes", 64'(ct_wr_count - ct_before), 64'd32);
        stop_run();

        // MSG_LEN=1 instance
        @(negedge clock) start_1 = 1'b1;
        @(posedge clock);
        edges = 0;
        while (!done_1 && edges < 200) begin
            @(posedge clock); #1; edges++;
        end
        $display("run: len1 done after %0d edges, ct writes %0d", edges, ct_wr_count_1);
        check_eq("len1_edges", 64'(edges), 64'd16);
        check_eq("len1_ct_writes", 64'(ct_wr_count_1), 64'd1);
        check_eq("len1_ct_addr", 64'(ct_last_addr_1), 64'd0);
        check_eq("len1_ct_data", 64'(ct_last_data_1), 64'h22);
        @(negedge clock) start_1 = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
